cpld_serial_if: RTL and testbench

Parametrised serial link between the FPGA and the board CPLD that drives the LEDs and multiplexed 7-segment display and returns the switch state. Each frame shifts out LED bits plus one segment byte, LSB first. The segment byte carries a hex digit with decimal point and blanking; digits are time-multiplexed one per frame. The block simultaneously shifts in a switch word and reports it with a valid strobe and a change-detect strobe. It replaces the fixed 8-LED / 2-digit interface in the top level.

---
 rtl/cpld_serial_if.sv | 166 ++++++++++++++++
 tb/tb_cpld_serial_if.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld_serial_if.sv
// Serial link to the board CPLD: shifts out LED bits plus one multiplexed 7-segment
// byte per frame (LSB first) while shifting in the switch word.
module cpld_serial_if #(
   parameter  int CLK_DIV_LOG2 = 10,
   parameter  int LED_W        = 8,
   parameter  int NUM_DIG      = 2,
   parameter  int SW_W         = 8,
   localparam int IDX_W        = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [LED_W-1:0]       led_i,
   input  logic [4*NUM_DIG-1:0]   dig_i,
   input  logic [NUM_DIG-1:0]     dp_i,
   input  logic [NUM_DIG-1:0]     blank_i,
   output logic [SW_W-1:0]        sw_o,
   output logic                   sw_valid_o,
   output logic                   sw_chg_o,
   output logic [IDX_W-1:0]       dig_idx_o,
   output logic                   cpld_clk_o,
   output logic                   cpld_load_o,
   output logic                   cpld_mosi_o,
   input  logic                   cpld_miso_i,
   output logic                   cpld_rstn_o,
   output logic                   cpld_jtagen_o
);

   localparam int FRAME = LED_W + 8;
   localparam int DIV_W = CLK_DIV_LOG2 + 1;
   localparam int B_W   = $clog2(FRAME);
   localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   logic [DIV_W-1:0]     div_q, div_d;
   logic [B_W-1:0]       bit_q, bit_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [1:0]           sync_q, sync_d;
   // Holds the FRAME-1 most recent bits; the frame's last bit is appended at frame_end.
   logic [FRAME-2:0]     shr_q, shr_d;
   logic [LED_W-1:0]     led_s_q, led_s_d;
   logic [4*NUM_DIG-1:0] dig_s_q, dig_s_d;
   logic [NUM_DIG-1:0]   dp_s_q, dp_s_d;
   logic [NUM_DIG-1:0]   blank_s_q, blank_s_d;
   logic [SW_W-1:0]      sw_q, sw_d;
   logic                 valid_q, valid_d;
   logic                 chg_q, chg_d;
   logic                 clk_q, clk_d;
   logic                 load_q, load_d;
   logic                 mosi_q, mosi_d;

   logic                 sclk, tick, frame_end;
   logic [3:0]           cur_dig;
   logic                 cur_dp, cur_blank;
   logic [7:0]           seg;
   logic [FRAME-1:0]     frame_w;
   logic [FRAME-1:0]     nxt;

   assign sclk      = div_q[CLK_DIV_LOG2];
   assign tick      = &div_q;
   assign frame_end = tick && (bit_q == B_LAST);
   assign nxt       = {sync_q[1], shr_q};

   always_comb begin
      cur_dig   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int n = 0; n < NUM_DIG; n++) begin
         if (idx_q == IDX_W'(n)) begin
            cur_dig   = dig_s_q[4*n +: 4];
            cur_dp    = dp_s_q[n];
            cur_blank = blank_s_q[n];
         end
      end
   end

   assign seg     = cur_blank ? 8'h00 : {cur_dp, hex7(cur_dig)};
   assign frame_w = {seg, led_s_q};

   always_comb begin
      div_d     = div_q + 1'b1;
      bit_d     = bit_q;
      idx_d     = idx_q;
      sync_d    = {sync_q[0], cpld_miso_i};
      shr_d     = shr_q;
      led_s_d   = led_s_q;
      dig_s_d   = dig_s_q;
      dp_s_d    = dp_s_q;
      blank_s_d = blank_s_q;
      sw_d      = sw_q;
      valid_d   = 1'b0;
      chg_d     = 1'b0;
      clk_d     = sclk;
      load_d    = (bit_q == B_LAST);
      mosi_d    = frame_w[bit_q];
      if (tick) begin
         bit_d = (bit_q == B_LAST) ? '0 : bit_q + 1'b1;
         shr_d = nxt[FRAME-1:1];
      end
      if (frame_end) begin
         idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         led_s_d   = led_i;
         dig_s_d   = dig_i;
         dp_s_d    = dp_i;
         blank_s_d = blank_i;
         sw_d      = nxt[SW_W-1:0];
         valid_d   = 1'b1;
         chg_d     = (nxt[SW_W-1:0] != sw_q);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q     <= '0;
         bit_q     <= '0;
         idx_q     <= '0;
         sync_q    <= '0;
         shr_q     <= '0;
         led_s_q   <= '0;
         dig_s_q   <= '0;
         dp_s_q    <= '0;
         blank_s_q <= '0;
         sw_q      <= '0;
         valid_q   <= 1'b0;
         chg_q     <= 1'b0;
         clk_q     <= 1'b0;
         load_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         bit_q     <= bit_d;
         idx_q     <= idx_d;
         sync_q    <= sync_d;
         shr_q     <= shr_d;
         led_s_q   <= led_s_d;
         dig_s_q   <= dig_s_d;
         dp_s_q    <= dp_s_d;
         blank_s_q <= blank_s_d;
         sw_q      <= sw_d;
         valid_q   <= valid_d;
         chg_q     <= chg_d;
         clk_q     <= clk_d;
         load_q    <= load_d;
         mosi_q    <= mosi_d;
      end
   end

   assign sw_o          = sw_q;
   assign sw_valid_o    = valid_q;
   assign sw_chg_o      = chg_q;
   assign dig_idx_o     = idx_q;
   assign cpld_clk_o    = clk_q;
   assign cpld_load_o   = load_q;
   assign cpld_mosi_o   = mosi_q;
   assign cpld_rstn_o   = ~rst_i;
   assign cpld_jtagen_o = 1'b0;

endmodule

// File: tb/tb_cpld_serial_if.sv
// Bench for cpld_serial_if: 2-digit instance driven from a vector table with a frame
// scoreboard and CPLD switch model, plus a free-running 3-digit blanking/wrap instance.
module tb_cpld_serial_if;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 2-digit instance
   logic [7:0]  led, dig, sw;
   logic [1:0]  dp, blank;
   logic        swv, swc, cclk, load, mosi, miso, rstn, jtag;
   logic [0:0]  didx;

   cpld_serial_if #(.CLK_DIV_LOG2(2), .LED_W(8), .NUM_DIG(2), .SW_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .led_i(led), .dig_i(dig), .dp_i(dp), .blank_i(blank),
      .sw_o(sw), .sw_valid_o(swv), .sw_chg_o(swc), .dig_idx_o(didx),
      .cpld_clk_o(cclk), .cpld_load_o(load), .cpld_mosi_o(mosi), .cpld_miso_i(miso),
      .cpld_rstn_o(rstn), .cpld_jtagen_o(jtag));

   // 3-digit instance, full-width switch word, constant inputs
   logic [7:0]  led3 = 8'h81;
   logic [11:0] dig3 = 12'h888;
   logic [2:0]  dp3 = 3'b110, blank3 = 3'b010;
   logic [15:0] sw3;
   logic        swv3, swc3, cclk3, load3, mosi3, rstn3, jtag3;
   logic [1:0]  didx3;

   cpld_serial_if #(.CLK_DIV_LOG2(1), .LED_W(8), .NUM_DIG(3), .SW_W(16)) dut3 (
      .clk_i(clk), .rst_i(rst), .led_i(led3), .dig_i(dig3), .dp_i(dp3), .blank_i(blank3),
      .sw_o(sw3), .sw_valid_o(swv3), .sw_chg_o(swc3), .dig_idx_o(didx3),
      .cpld_clk_o(cclk3), .cpld_load_o(load3), .cpld_mosi_o(mosi3), .cpld_miso_i(1'b1),
      .cpld_rstn_o(rstn3), .cpld_jtagen_o(jtag3));

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   typedef struct { int fn; logic [15:0] word; logic [0:0] idx; } fexp_t;
   typedef struct { logic [7:0] sw; logic chg; } sexp_t;
   typedef struct { logic [7:0] led, dig; logic [1:0] dp, blank; logic [7:0] seg0, seg1; } vec_t;

   fexp_t       fq[$];
   sexp_t       sq[$];
   int          fcnt = 0, frames_chk = 0, valids = 0, stray = 0, frames3 = 0;
   logic [15:0] sw_word = 16'h5A3C;

   // Frame receiver + CPLD switch model for the 2-digit instance
   initial begin
      int bitn; logic pclk; logic [15:0] fbits, mbits; logic [7:0] sw_model; sexp_t se;
      bitn = 0; pclk = 1'b0; sw_model = 8'h00; miso = 1'b0; fbits = '0; mbits = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            fcnt = 0; bitn = 0; pclk = 1'b0; sw_model = 8'h00;
            fq.delete(); sq.delete();
         end else begin
            if (cclk && !pclk) begin
               miso = sw_word[bitn];
               mbits[bitn] = sw_word[bitn];
               fbits[bitn] = mosi;
               if (load) begin
                  chk("frame_len", bitn, 15);
                  if (fq.size() > 0 && fq[0].fn == fcnt) begin
                     chk("frame_word", fbits, fq[0].word);
                     chk("dig_idx", didx, fq[0].idx);
                     void'(fq.pop_front());
                     frames_chk++;
                  end
                  se.sw = mbits[7:0];
                  se.chg = (mbits[7:0] != sw_model);
                  sq.push_back(se);
                  sw_model = mbits[7:0];
                  fcnt++;
                  bitn = 0;
               end else if (bitn < 15) bitn++;
            end
            pclk = cclk;
         end
      end
   end

   // Switch strobe checker
   initial begin
      logic pv; logic [7:0] last_sw; sexp_t e;
      pv = 1'b0; last_sw = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0; last_sw = 8'h00;
         end else begin
            if (swv) begin
               chk("sw_pulse_width", pv, 1'b0);
               if (sq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sw_valid_unexpected got=1 exp=0 sw_o=%0h", sw);
               end else begin
                  e = sq.pop_front();
                  chk("sw_o", sw, e.sw);
                  chk("sw_chg", swc, e.chg);
                  valids++;
               end
               last_sw = sw;
            end else if (swc || sw !== last_sw) stray++;
            pv = swv;
         end
      end
   end

   // 3-digit instance: frame 0 is the zero snapshot, then digits 0,1,2 repeat
   initial begin
      int bitn, fn; logic pclk; logic [15:0] fbits; logic [7:0] exp3[3];
      exp3[0] = 8'h7F; exp3[1] = 8'h00; exp3[2] = 8'hFF;
      bitn = 0; fn = 0; pclk = 1'b0; fbits = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bitn = 0; fn = 0; pclk = 1'b0;
         end else begin
            if (cclk3 && !pclk) begin
               fbits[bitn] = mosi3;
               if (load3) begin
                  chk("d3_frame_len", bitn, 15);
                  chk("d3_frame_word", fbits, (fn == 0) ? 16'h3F00 : {exp3[fn % 3], 8'h81});
                  chk("d3_dig_idx", didx3, fn % 3);
                  frames3++;
                  fn++;
                  bitn = 0;
               end else if (bitn < 15) bitn++;
            end
            pclk = cclk3;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_load_rise();
      int n; logic seen, p;
      n = 0; seen = 1'b0; p = load;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         if (load && !p) seen = 1'b1;
         p = load;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL load_timeout got=none exp=load_rise");
      end
   endtask

   task automatic wait_sclk_rises(input int cnt);
      int n, r; logic p;
      n = 0; r = 0; p = cclk;
      while (r < cnt && n < 400) begin
         @(negedge clk);
         n++;
         if (cclk && !p) r++;
         p = cclk;
      end
      if (r < cnt) begin
         total++; bad++;
         $display("FAIL sclk_timeout got=%0d exp=%0d", r, cnt);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (fq.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (fq.size() > 0) begin
         total++; bad++;
         $display("FAIL frame_drain got=%0d exp=0", fq.size());
      end
   endtask

   // Apply inputs at the current frame's last bit; they show up in the following frame.
   task automatic next_frame(input vec_t v);
      fexp_t fe;
      wait_load_rise();
      led = v.led; dig = v.dig; dp = v.dp; blank = v.blank;
      fe.fn = fcnt + 1;
      fe.idx = fe.fn[0];
      fe.word = {(fe.fn % 2 == 1) ? v.seg1 : v.seg0, v.led};
      fq.push_back(fe);
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_sw_o"}, sw, 0);
      chk({tag, "_sw_valid"}, swv, 0);
      chk({tag, "_sw_chg"}, swc, 0);
      chk({tag, "_dig_idx"}, didx, 0);
      chk({tag, "_cpld_clk"}, cclk, 0);
      chk({tag, "_cpld_load"}, load, 0);
      chk({tag, "_cpld_mosi"}, mosi, 0);
      chk({tag, "_rstn"}, rstn, 0);
      chk({tag, "_jtagen"}, jtag, 0);
   endtask

   task automatic push_zero_frame();
      fexp_t fe;
      fe.fn = 0; fe.idx = 1'b0; fe.word = 16'h3F00;
      fq.push_back(fe);
   endtask

   initial begin
      vec_t vt[8];
      vec_t v_lo, v_hi;
      int err_l, err_c;
      vt[0] = '{8'hA5, 8'h31, 2'b10, 2'b00, 8'h06, 8'hCF};
      vt[1] = '{8'h00, 8'hFE, 2'b01, 2'b00, 8'hF9, 8'h71};
      vt[2] = '{8'hFF, 8'h2B, 2'b11, 2'b01, 8'h00, 8'hDB};
      vt[3] = '{8'h3C, 8'hD9, 2'b00, 2'b10, 8'h6F, 8'h00};
      vt[4] = '{8'h81, 8'hC7, 2'b00, 2'b00, 8'h07, 8'h39};
      vt[5] = '{8'h5A, 8'h64, 2'b10, 2'b00, 8'h66, 8'hFD};
      vt[6] = '{8'h0F, 8'hA0, 2'b00, 2'b00, 8'h3F, 8'h77};
      vt[7] = '{8'h12, 8'h85, 2'b01, 2'b00, 8'hED, 8'h7F};
      v_lo  = '{8'h00, 8'h31, 2'b00, 2'b00, 8'h06, 8'h4F};
      v_hi  = '{8'hFF, 8'h31, 2'b00, 2'b00, 8'h06, 8'h4F};
      led = 8'h00; dig = 8'h00; dp = 2'b00; blank = 2'b00;

      repeat (3) @(negedge clk);
      check_rst("por");

      // Release and check the exact sclk/load timing of the first frame
      rst = 1'b0;
      #1 push_zero_frame();
      chk("rstn_released", rstn, 1);
      err_l = 0; err_c = 0;
      for (int k = 1; k <= 140; k++) begin
         @(negedge clk);
         if (load !== ((k >= 121 && k <= 128) ? 1'b1 : 1'b0)) err_l++;
         if (cclk !== ((((k - 1) % 8) >= 4) ? 1'b1 : 1'b0)) err_c++;
      end
      chk("load_window", err_l, 0);
      chk("sclk_phase", err_c, 0);

      // Vector table, each vector held two frames so both digits are seen
      for (int i = 0; i < 8; i++) begin
         sw_word = {8'h5A, vt[i].led};
         repeat (2) next_frame(vt[i]);
      end

      // LEDs change at bit 3 of a frame: that frame still carries the old snapshot
      next_frame(v_lo);
      wait_sclk_rises(5);
      led = 8'hFF;
      next_frame(v_hi);
      next_frame(v_hi);
      wait_drain();

      // Reset mid-frame while the switch word is shifting in
      wait_load_rise();
      wait_sclk_rises(6);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_rst("midrst");
      repeat (3) @(negedge clk);
      sw_word = 16'hFFC3;
      rst = 1'b0;
      #1 push_zero_frame();
      next_frame(vt[0]);
      sw_word = 16'h11C3;
      next_frame(vt[0]);
      wait_drain();
      repeat (10) @(negedge clk);

      chk("stray_strobes", stray, 0);
      chk("frames_checked_min", (frames_chk >= 20) ? 1 : 0, 1);
      chk("sw_valids_min", (valids >= 20) ? 1 : 0, 1);
      chk("d3_frames_min", (frames3 >= 10) ? 1 : 0, 1);
      chk("d3_sw_full_width", sw3, 16'hFFFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
